// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the DMA peripheral responder.
package dma_pkg;
  localparam int DMA_DATA_W = 8;
  typedef enum logic [2:0] {IDLE, ARM, REQ, XFER, DONE, HALT} dma_resp_state_e;
  typedef enum logic {DIR_IN = 1'b0, DIR_OUT = 1'b1} dma_dir_e;
  typedef enum logic {MODE_SINGLE = 1'b0, MODE_DEMAND = 1'b1} dma_mode_e;
endpackage

// File: rtl/dma_sync_fifo.sv
// dma_sync_fifo: single-clock FIFO with first-word-fall-through head.
module dma_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              push,
  input  logic [DATA_W-1:0] pushData,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0] count;
  logic doPush, doPop;
  assign full   = count == (AW+1)'(DEPTH);
  assign empty  = count == '0;
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign head   = mem[rdPtr];
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop) rdPtr <= rdPtr + AW'(1);
      count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  end
  always_ff @(posedge CLK) begin
    if (doPush) mem[wrPtr] <= pushData;
  end
endmodule

// File: rtl/dma_peripheral_responder.sv
// dma_peripheral_responder: device end of the 8237A DREQ/DACK handshake,
// serving IOR_N/IOW_N strobes from an internal FIFO.
module dma_peripheral_responder
  import dma_pkg::*;
#(
  parameter int DATA_W = DMA_DATA_W,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              EN,
  input  logic              DIR,
  input  logic              DEMAND,
  input  logic [CNT_W-1:0]  XFER_CNT,
  output logic              DREQ,
  input  logic              DACK,
  input  logic              IOR_N,
  input  logic              IOW_N,
  input  logic              EOP_N_IN,
  output logic              EOP_N_OUT,
  input  logic [DATA_W-1:0] DB_IN,
  output logic [DATA_W-1:0] DB_OUT,
  output logic              DB_OE,
  input  logic              PUSH_VLD,
  input  logic [DATA_W-1:0] PUSH_DATA,
  output logic              PUSH_RDY,
  output logic              POP_VLD,
  output logic [DATA_W-1:0] POP_DATA,
  input  logic              POP_RDY,
  output logic              DONE,
  output logic              OVR,
  output logic              UNR
);
  dma_resp_state_e state;
  logic [CNT_W:0] cnt, cntNext;
  logic [DATA_W-1:0] capData, head;
  logic enPrev, iorSeen, iowSeen, dirOut, demand, busy, inXfer, running;
  logic iorActive, iowActive, iorRise, iowRise, strobeDone;
  logic full, empty, ready, eopIn, localPop, fifoPush, fifoPop;
  assign dirOut  = dma_dir_e'(DIR) == DIR_OUT;
  assign demand  = dma_mode_e'(DEMAND) == MODE_DEMAND;
  assign busy    = state != IDLE;
  assign inXfer  = state == XFER;
  assign running = state inside {ARM, REQ, XFER};
  // A strobe that began in XFER is seen through to its rising edge even if EOP ends the transfer meanwhile.
  assign iorActive  = !IOR_N && DACK && !dirOut && busy && (inXfer || iorSeen);
  assign iowActive  = !IOW_N && DACK && dirOut && busy && (inXfer || iowSeen);
  assign iorRise    = busy && iorSeen && IOR_N;
  assign iowRise    = busy && iowSeen && IOW_N;
  assign strobeDone = iorRise || iowRise;
  assign cntNext    = (strobeDone && cnt != '0) ? cnt - (CNT_W+1)'(1) : cnt;
  assign ready      = dirOut ? !full : !empty;
  assign eopIn      = !EOP_N_IN && DACK;
  assign localPop   = POP_VLD && POP_RDY;
  assign fifoPush   = dirOut ? iowRise && (!full || localPop) : PUSH_VLD && PUSH_RDY;
  assign fifoPop    = dirOut ? localPop : iorRise && !empty;
  assign DREQ      = EN && (state == REQ || inXfer);
  assign DB_OE     = iorActive;
  assign DB_OUT    = !iorActive ? '0 : empty ? '1 : head;
  assign EOP_N_OUT = !((iorActive || iowActive) && cnt == (CNT_W+1)'(1));
  assign DONE      = state == dma_pkg::DONE;
  assign PUSH_RDY  = !dirOut && !full;
  assign POP_VLD   = dirOut && !empty;
  assign POP_DATA  = head;
  dma_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .push    (fifoPush),
    .pushData(dirOut ? capData : PUSH_DATA),
    .pop     (fifoPop),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      cnt     <= '0;
      enPrev  <= 1'b0;
      iorSeen <= 1'b0;
      iowSeen <= 1'b0;
      capData <= '0;
      OVR     <= 1'b0;
      UNR     <= 1'b0;
    end else begin
      enPrev  <= EN;
      iorSeen <= iorActive;
      iowSeen <= iowActive;
      cnt     <= cntNext;
      if (iowActive) capData <= DB_IN;
      if (enPrev && !EN) begin
        OVR <= 1'b0;
        UNR <= 1'b0;
      end else begin
        if (iowRise && full && !localPop) OVR <= 1'b1;
        if (iorRise && empty) UNR <= 1'b1;
      end
      if (!EN) state <= IDLE;
      else if (running && (eopIn || cntNext == '0)) state <= dma_pkg::DONE;
      else begin
        case (state)
          IDLE: if (!enPrev) begin
            state <= ARM;
            cnt   <= {XFER_CNT == '0, XFER_CNT};
          end
          ARM:  if (ready) state <= REQ;
          REQ:  if (DACK) state <= XFER;
          XFER: if (strobeDone && (!demand || !ready)) state <= ARM;
          dma_pkg::DONE: state <= HALT;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dma_peripheral_responder.sv
// tb_dma_peripheral_responder: directed scenarios against hand-computed results.
module tb_dma_peripheral_responder;
  logic CLK = 0, RESET_N = 0, EN = 0, DIR = 0, DEMAND = 0;
  logic [15:0] XFER_CNT = '0;
  logic DACK = 0, IOR_N = 1, IOW_N = 1, EOP_N_IN = 1;
  logic [7:0] DB_IN = '0, PUSH_DATA = '0;
  logic PUSH_VLD = 0, POP_RDY = 0;
  logic DREQ, EOP_N_OUT, DB_OE, PUSH_RDY, POP_VLD, DONE, OVR, UNR;
  logic [7:0] DB_OUT, POP_DATA;
  int checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  dma_peripheral_responder dut (
    .CLK(CLK), .RESET_N(RESET_N), .EN(EN), .DIR(DIR), .DEMAND(DEMAND),
    .XFER_CNT(XFER_CNT), .DREQ(DREQ), .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N),
    .EOP_N_IN(EOP_N_IN), .EOP_N_OUT(EOP_N_OUT), .DB_IN(DB_IN), .DB_OUT(DB_OUT),
    .DB_OE(DB_OE), .PUSH_VLD(PUSH_VLD), .PUSH_DATA(PUSH_DATA), .PUSH_RDY(PUSH_RDY),
    .POP_VLD(POP_VLD), .POP_DATA(POP_DATA), .POP_RDY(POP_RDY), .DONE(DONE),
    .OVR(OVR), .UNR(UNR)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic push_byte(input logic [7:0] d);
    PUSH_VLD = 1; PUSH_DATA = d; tick(); PUSH_VLD = 0;
  endtask

  task automatic wait_dreq(output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) if (DREQ) ok = 1; else tick();
  endtask

  task automatic ior_strobe(output logic [7:0] d, output logic oe, output logic eop,
                            output logic dq, output logic dn);
    DACK = 1; tick(); IOR_N = 0; #1;
    d = DB_OUT; oe = DB_OE; eop = EOP_N_OUT;
    tick(); IOR_N = 1; tick();
    dq = DREQ; dn = DONE; DACK = 0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (DREQ !== 1'b0) begin errors++; $display("FAIL rst_dreq: got %b want 0", DREQ); end
    checks++; if (EOP_N_OUT !== 1'b1) begin errors++; $display("FAIL rst_eop: got %b want 1", EOP_N_OUT); end
    checks++; if ({DB_OE, DB_OUT} !== 9'h0) begin errors++; $display("FAIL rst_bus: got %b/%h want 0/00", DB_OE, DB_OUT); end
    checks++; if ({DONE, OVR, UNR} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {DONE, OVR, UNR}); end
    checks++; if ({PUSH_RDY, POP_VLD} !== 2'b10) begin errors++; $display("FAIL rst_fifo: got %b want 10", {PUSH_RDY, POP_VLD}); end
    tick(); RESET_N = 1; tick();
  endtask

  task automatic test_single_ior;
    logic [7:0] d; logic oe, eop, dq, dn; bit ok;
    DIR = 0; DEMAND = 0;
    push_byte(8'hA5); push_byte(8'h3C);
    XFER_CNT = 16'd2; EN = 1;
    wait_dreq(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t1_dreq1: got timeout want DREQ=1"); end
    ior_strobe(d, oe, eop, dq, dn);
    checks++; if ({oe, d} !== 9'h1A5) begin errors++; $display("FAIL t1_byte1: got %b/%h want 1/a5", oe, d); end
    checks++; if ({eop, dq, dn} !== 3'b100) begin errors++; $display("FAIL t1_after1: got eop/dreq/done %b want 100", {eop, dq, dn}); end
    wait_dreq(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t1_dreq2: got timeout want DREQ=1"); end
    ior_strobe(d, oe, eop, dq, dn);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL t1_byte2: got %h want 3c", d); end
    checks++; if ({eop, dq, dn} !== 3'b001) begin errors++; $display("FAIL t1_after2: got eop/dreq/done %b want 001", {eop, dq, dn}); end
    tick();
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL t1_done_pulse: got %b want 0", DONE); end
    EN = 0; tick();
  endtask

  task automatic test_demand_iow;
    bit ok;
    DIR = 1; DEMAND = 1; XFER_CNT = 16'd4; EN = 1;
    wait_dreq(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t2_dreq: got timeout want DREQ=1"); end
    DACK = 1; tick();
    for (int b = 1; b <= 4; b++) begin
      IOW_N = 0; DB_IN = 8'(b); #1;
      checks++; if (EOP_N_OUT !== (b != 4)) begin errors++; $display("FAIL t2_eop%0d: got %b want %b", b, EOP_N_OUT, b != 4); end
      tick(); tick(); IOW_N = 1; tick();
      if (b < 4) begin
        checks++; if (DREQ !== 1'b1) begin errors++; $display("FAIL t2_dreq_held%0d: got %b want 1", b, DREQ); end
      end else begin
        checks++; if ({DONE, DREQ} !== 2'b10) begin errors++; $display("FAIL t2_done: got done/dreq %b want 10", {DONE, DREQ}); end
      end
    end
    DACK = 0; tick();
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL t2_done_once: got %b want 0", DONE); end
    EN = 0; tick();
    for (int i = 1; i <= 4; i++) begin
      checks++; if ({POP_VLD, POP_DATA} !== {1'b1, 8'(i)}) begin errors++; $display("FAIL t2_pop%0d: got %b/%h want 1/%h", i, POP_VLD, POP_DATA, 8'(i)); end
      POP_RDY = 1; tick(); POP_RDY = 0;
    end
    checks++; if (POP_VLD !== 1'b0) begin errors++; $display("FAIL t2_empty: got %b want 0", POP_VLD); end
  endtask

  task automatic test_eop_abort;
    logic [7:0] d; logic oe, eop, dq, dn; bit ok; int seen = 0;
    DIR = 0; DEMAND = 0;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    XFER_CNT = 16'd8; EN = 1;
    wait_dreq(ok);
    ior_strobe(d, oe, eop, dq, dn);
    checks++; if ({d, dq} !== {8'h11, 1'b0}) begin errors++; $display("FAIL t3_byte1: got %h/%b want 11/0", d, dq); end
    wait_dreq(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t3_dreq2: got timeout want DREQ=1"); end
    DACK = 1; tick(); IOR_N = 0; EOP_N_IN = 0; #1;
    checks++; if (DB_OUT !== 8'h22) begin errors++; $display("FAIL t3_byte2: got %h want 22", DB_OUT); end
    tick();
    checks++; if ({DONE, DREQ} !== 2'b10) begin errors++; $display("FAIL t3_done: got done/dreq %b want 10", {DONE, DREQ}); end
    EOP_N_IN = 1; IOR_N = 1; tick(); DACK = 0;
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL t3_done_once: got %b want 0", DONE); end
    repeat (5) begin tick(); if (DREQ || DONE) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL t3_halt: got %0d active cycles want 0", seen); end
    EN = 0; tick(); DIR = 1; #1;
    checks++; if ({POP_VLD, POP_DATA} !== {1'b1, 8'h33}) begin errors++; $display("FAIL t3_left: got %b/%h want 1/33", POP_VLD, POP_DATA); end
    POP_RDY = 1; tick(); POP_RDY = 0;
    checks++; if (POP_VLD !== 1'b0) begin errors++; $display("FAIL t3_empty: got %b want 0", POP_VLD); end
  endtask

  task automatic test_underrun_overrun;
    logic [7:0] d; logic oe, eop, dq, dn, dq15; bit ok; int bad = 0;
    DIR = 0; DEMAND = 1;
    push_byte(8'h9E);
    XFER_CNT = 16'd3; EN = 1;
    wait_dreq(ok);
    ior_strobe(d, oe, eop, dq, dn);
    checks++; if ({d, dq} !== {8'h9E, 1'b1}) begin errors++; $display("FAIL t4_first: got %h/%b want 9e/1", d, dq); end
    ior_strobe(d, oe, eop, dq, dn);
    checks++; if ({d, dq} !== {8'hFF, 1'b0}) begin errors++; $display("FAIL t4_empty_read: got %h/%b want ff/0", d, dq); end
    checks++; if (UNR !== 1'b1) begin errors++; $display("FAIL t4_unr: got %b want 1", UNR); end
    EN = 0; tick();
    checks++; if (UNR !== 1'b0) begin errors++; $display("FAIL t4_unr_clear: got %b want 0", UNR); end
    DIR = 1; XFER_CNT = 16'd20; EN = 1;
    wait_dreq(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t4_dreq: got timeout want DREQ=1"); end
    DACK = 1; tick();
    dq15 = 0;
    for (int i = 0; i <= 16; i++) begin
      IOW_N = 0; DB_IN = 8'h40 + 8'(i); tick(); IOW_N = 1; tick();
      if (i == 15) dq15 = DREQ;
    end
    DACK = 0;
    checks++; if (dq15 !== 1'b1) begin errors++; $display("FAIL t4_dreq16: got %b want 1", dq15); end
    checks++; if ({OVR, DREQ} !== 2'b10) begin errors++; $display("FAIL t4_ovr: got ovr/dreq %b want 10", {OVR, DREQ}); end
    EN = 0; tick();
    checks++; if (OVR !== 1'b0) begin errors++; $display("FAIL t4_ovr_clear: got %b want 0", OVR); end
    for (int i = 0; i < 16; i++) begin
      if ({POP_VLD, POP_DATA} !== {1'b1, 8'h40 + 8'(i)}) bad++;
      POP_RDY = 1; tick(); POP_RDY = 0;
    end
    checks++; if (bad != 0 || POP_VLD !== 1'b0) begin errors++; $display("FAIL t4_fifo_contents: got %0d bad entries, vld %b want 0, 0", bad, POP_VLD); end
  endtask

  task automatic test_reset_mid_strobe;
    bit ok;
    DIR = 0; DEMAND = 0;
    push_byte(8'h5A);
    XFER_CNT = 16'd1; EN = 1;
    wait_dreq(ok);
    DACK = 1; tick(); IOR_N = 0; #1;
    checks++; if ({DB_OE, EOP_N_OUT, DB_OUT} !== {2'b10, 8'h5A}) begin errors++; $display("FAIL t5_strobe: got oe/eop %b%b data %h want 10/5a", DB_OE, EOP_N_OUT, DB_OUT); end
    RESET_N = 0; #1;
    checks++; if ({DB_OE, DREQ, EOP_N_OUT} !== 3'b001) begin errors++; $display("FAIL t5_drop: got oe/dreq/eop %b want 001", {DB_OE, DREQ, EOP_N_OUT}); end
    checks++; if ({DONE, OVR, UNR, DB_OUT} !== 11'h0) begin errors++; $display("FAIL t5_flags: got %b/%h want 000/00", {DONE, OVR, UNR}, DB_OUT); end
    tick(); IOR_N = 1; DACK = 0; EN = 0; RESET_N = 1; tick(); DIR = 1; #1;
    checks++; if (POP_VLD !== 1'b0) begin errors++; $display("FAIL t5_fifo_cleared: got %b want 0", POP_VLD); end
    DIR = 0; tick();
  endtask

  task automatic test_en_drop;
    bit ok; int oeSeen = 0, doneSeen = 0;
    DIR = 0; DEMAND = 0;
    push_byte(8'h77);
    XFER_CNT = 16'd1; EN = 1;
    wait_dreq(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t6_dreq: got timeout want DREQ=1"); end
    EN = 0; tick();
    checks++; if ({DREQ, DONE} !== 2'b00) begin errors++; $display("FAIL t6_drop: got dreq/done %b want 00", {DREQ, DONE}); end
    DACK = 1;
    repeat (3) begin
      IOR_N = 0; tick();
      if (DB_OE) oeSeen++;
      if (DONE) doneSeen++;
      IOR_N = 1; tick();
      if (DONE) doneSeen++;
    end
    DACK = 0;
    checks++; if (oeSeen != 0 || doneSeen != 0) begin errors++; $display("FAIL t6_ignored: got oe %0d done %0d want 0 0", oeSeen, doneSeen); end
    DIR = 1; #1;
    checks++; if ({POP_VLD, POP_DATA} !== {1'b1, 8'h77}) begin errors++; $display("FAIL t6_fifo: got %b/%h want 1/77", POP_VLD, POP_DATA); end
    POP_RDY = 1; tick(); POP_RDY = 0; DIR = 0; tick();
  endtask

  initial begin
    test_reset();
    test_single_ior();
    test_demand_iow();
    test_eop_abort();
    test_underrun_overrun();
    test_reset_mid_strobe();
    test_en_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
